mul_div_unit: RTL
=================

# mul_div_unit

Iterative HI/LO multiply/divide unit in the EX stage of the 5-stage MIPS core. The single-cycle ALU cannot handle MULT, MULTU, DIV or DIVU, so the ID/EX control issues them here through a start/busy/done handshake. The unit computes one bit per cycle and commits a 64-bit result into the architectural HI/LO registers. It also serves MTHI/MTLO writes and drives HI/LO out for MFHI/MFLO forwarding.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  issue request; sampled only in IDLE
- md_op  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  in  32  multiplicand or dividend
- rt_data  in  32  multiplier or divisor
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO write data
- busy  out  1  operation in progress; pipeline stalls on MFHI/MFLO/new md op while high
- done  out  1  one-cycle pulse, registered, on the cycle HI/LO take the new result
- div_by_zero  out  1  one-cycle pulse with done when a DIV/DIVU had rt_data = 0
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- State machine: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 latches md_op and operands, clears the iteration counter, and goes to CALC.
  - Signed ops latch absolute values and record result sign(s); unsigned ops latch raw values.
- CALC: exactly 32 cycles, counter 0..31, then FIX.
  - Multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- FIX: one cycle. Applies sign correction, writes HI/LO, pulses done and returns to IDLE.
- Result rules:
  - MULT/MULTU: {hi,lo} = full 64-bit product. MULT is two's-complement, MULTU unsigned.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - DIV: quotient truncates toward zero, and the remainder takes the sign of the dividend.
  - Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero:
  - Both DIV and DIVU give lo=0xFFFFFFFF and hi=rs_data as latched.
  - div_by_zero pulses with done.
  - Latency is unchanged at 33 cycles; there is no early exit.
- MTHI/MTLO:
  - hi_we writes hi and lo_we writes lo with wdata in IDLE, effective the next cycle.
  - Both may be set together.
- Priority and collisions:
  - start and hi_we/lo_we in the same IDLE cycle: start wins and the write is dropped.
  - start, hi_we and lo_we are ignored while busy. The pipeline guarantees no issue during busy, but the block must not corrupt state if it happens.
- Operand inputs are don't-care except on the start cycle.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.
- Start cycle: start is sampled at edge E0.
- busy:
  - Driven from state, asserted from just after E0 through E33.
  - High for exactly 33 cycles: 32 CALC cycles plus 1 FIX cycle.
- Commit:
  - Edge E33 writes hi/lo, sets done=1 and div_by_zero as applicable, and drops busy.
  - done and div_by_zero are high for the one cycle after E33.
- Back-to-back:
  - A new start may be sampled on the first IDLE cycle after E33, i.e. while done=1.
  - Issue-to-issue minimum is 34 cycles.
- hi/lo hold their previous values throughout CALC; no partial results are visible.
- Reset mid-operation: asynchronously aborts. busy drops immediately, hi/lo clear to 0, and no done is produced.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=7 -> after 33 busy cycles: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse 1 cycle.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV signed cases:
  - rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero and done pulse together.
- Collisions:
  - start at cycle 5 of CALC with new operands, plus lo_we -> ignored; original result committed unchanged.
  - In IDLE: start and hi_we in the same cycle -> hi not written by wdata.
- rst asserted mid-edge at CALC cycle 10 of a DIVU -> busy=0 immediately, hi=lo=0, no done.
  - After release, MTLO wdata=0x12345678 -> lo=0x12345678 next cycle.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between ID/EX control and the HI/LO multiply/divide unit.
interface mul_div_unit_if;
   logic        start;
   logic [1:0]  md_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, md_op, rs_data, rt_data, hi_we, lo_we, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, md_op, rs_data, rt_data, hi_we, lo_we, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: one result bit per cycle, 33-cycle latency.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; serves MTHI/MTLO writes
// S_CALC | 32 iterations of shift-add multiply or restoring divide
// S_FIX  | sign correction, commit to HI/LO, pulse done
module mul_div_unit (
   input  logic          clk,
   input  logic          rst,
   mul_div_unit_if.slave md
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic        is_div;
   logic        neg_q;
   logic        neg_r;
   logic        dbz;
   logic [63:0] acc;
   logic [31:0] b;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;
   logic        dbz_q;

   logic        op_signed;
   logic [31:0] abs_rs;
   logic [31:0] abs_rt;
   logic [32:0] mul_sum;
   logic [32:0] rem_shift;
   logic        div_ge;
   logic [31:0] div_sub;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // Operand conditioning on issue and per-iteration datapath.
   // For divide, acc holds {partial remainder, dividend/quotient}; since the
   // remainder is always below the divisor, a set bit 32 of the shifted
   // remainder already implies it exceeds the divisor, and the 32-bit
   // difference is then exact.
   always_comb begin
      op_signed = ~md.md_op[0];
      abs_rs    = (op_signed && md.rs_data[31]) ? -md.rs_data : md.rs_data;
      abs_rt    = (op_signed && md.rt_data[31]) ? -md.rt_data : md.rt_data;
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b} : 33'd0);
      rem_shift = acc[63:31];
      div_ge    = rem_shift[32] | (rem_shift[31:0] >= b);
      div_sub   = rem_shift[31:0] - b;
      prod_fix  = neg_q ? -acc : acc;
      quo_fix   = neg_q ? -acc[31:0] : acc[31:0];
      rem_fix   = neg_r ? -acc[63:32] : acc[63:32];
   end

   // Sequencer, iteration datapath and HI/LO architectural registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= 5'd0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dbz    <= 1'b0;
         acc    <= 64'd0;
         b      <= 32'd0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (md.start) begin
                  is_div <= md.md_op[1];
                  neg_q  <= op_signed & (md.rs_data[31] ^ md.rt_data[31]);
                  neg_r  <= op_signed & md.rs_data[31];
                  dbz    <= md.md_op[1] & (md.rt_data == 32'd0);
                  acc    <= {32'd0, abs_rs};
                  b      <= abs_rt;
                  cnt    <= 5'd0;
                  state  <= S_CALC;
               end else begin
                  if (md.hi_we) hi_q <= md.wdata;
                  if (md.lo_we) lo_q <= md.wdata;
               end
            end
            S_CALC: begin
               if (is_div)
                  acc <= {(div_ge ? div_sub : rem_shift[31:0]), acc[30:0], div_ge};
               else
                  acc <= {mul_sum, acc[31:1]};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= S_FIX;
            end
            S_FIX: begin
               if (is_div) begin
                  hi_q <= rem_fix;
                  lo_q <= dbz ? 32'hFFFF_FFFF : quo_fix;
               end else begin
                  hi_q <= prod_fix[63:32];
                  lo_q <= prod_fix[31:0];
               end
               done_q <= 1'b1;
               dbz_q  <= dbz;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign md.busy        = (state != S_IDLE);
   assign md.done        = done_q;
   assign md.div_by_zero = dbz_q;
   assign md.hi          = hi_q;
   assign md.lo          = lo_q;

endmodule
